// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave backed by a word-organised register-array SRAM.
// It supports byte, halfword and word accesses and inserts a fixed number of
// wait states (WAIT_STATES) before each OKAY data phase completes. Illegal
// accesses receive the two-cycle ERROR response.
// Optional build macro: AHB_SRAM_WRITE_PROTECT_EN adds a write-protect input,
// wp_i, which turns accepted writes into ERROR responses.
//
// Handshake: the master has a valid address phase when sHSEL & sHTRANS[1].
// That phase is taken at a rising edge only when sHREADY is also 1. A data
// phase completes on the cycle where sHREADYOUT is 1. sHRESP qualifies that
// completion: 0 means OKAY and 1 means ERROR.
// Debug: dbg_state exposes the encoding of the current FSM state.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        sHSEL,
  input  logic [31:0] sHADDR,
  input  logic [1:0]  sHTRANS,
  input  logic        sHWRITE,
  input  logic [2:0]  sHSIZE,
  input  logic [2:0]  sHBURST,
  input  logic [31:0] sHWDATA,
  input  logic        sHREADY,
`ifdef AHB_SRAM_WRITE_PROTECT_EN
  input  logic        wp_i,
`endif
  output logic        sHREADYOUT,
  output logic        sHRESP,
  output logic [31:0] sHRDATA,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_ACCESS = 3'd2,
    S_ERR1   = 3'd3,
    S_ERR2   = 3'd4
  } state_t;

  localparam int          DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                  state, state_next;
  logic [3:0]              wait_cnt;
  logic [ADDR_WIDTH+1:0]   addr_q;
  logic                    write_q;
  logic [1:0]              size_q;
  logic [31:0]             rdata_q;
  logic [3:0]              strb;
  logic                    accept;
  logic                    addr_err;
  logic                    capture;
  logic                    rd_active;
  state_t                  accept_next;
  logic [31:0]             mem [DEPTH];

  // Burst type is not needed for decode; SEQ and NONSEQ share the same path.
  logic unused_bits;
  assign unused_bits = ^{sHBURST, sHTRANS[0]};

  assign accept = sHSEL & sHREADY & sHTRANS[1];

  // Decode illegal accesses during the address phase.
  always_comb begin
    addr_err = 1'b0;
    if (sHADDR[31:ADDR_WIDTH+2] != '0) addr_err = 1'b1;
    if (sHSIZE > 3'd2) addr_err = 1'b1;
    if (sHSIZE == 3'd1 && sHADDR[0]) addr_err = 1'b1;
    if (sHSIZE == 3'd2 && sHADDR[1:0] != 2'b00) addr_err = 1'b1;
`ifdef AHB_SRAM_WRITE_PROTECT_EN
    if (sHWRITE && wp_i) addr_err = 1'b1;
`endif
  end

  assign accept_next = addr_err ? S_ERR1 : ((WAIT_STATES == 0) ? S_ACCESS : S_WAIT);

  // Hold the state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_next;
  end

  // Compute the next state and the response outputs.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    sHREADYOUT = 1'b1;
    sHRESP     = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          capture    = 1'b1;
          state_next = accept_next;
        end
      end
      S_WAIT: begin
        sHREADYOUT = 1'b0;
        if (wait_cnt == 4'd0) state_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (accept) begin
          capture    = 1'b1;
          state_next = accept_next;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ERR1: begin
        sHREADYOUT = 1'b0;
        sHRESP     = 1'b1;
        state_next = S_ERR2;
      end
      S_ERR2: begin
        sHRESP = 1'b1;
        if (accept) begin
          capture    = 1'b1;
          state_next = accept_next;
        end else if (sHREADY) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign dbg_state = state;

  // Load the wait counter on entry to WAIT, then count down to zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wait_cnt <= 4'd0;
    end else if (capture && !addr_err && WAIT_STATES != 0) begin
      wait_cnt <= WAIT_LOAD;
    end else if (state == S_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Capture the address-phase attributes of each accepted transfer.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
    end else if (capture) begin
      addr_q  <= sHADDR[ADDR_WIDTH+1:0];
      write_q <= sHWRITE;
      size_q  <= sHSIZE[1:0];
    end
  end

  // Derive the byte lanes that a write updates, from size and low address bits.
  always_comb begin
    strb = 4'b0000;
    case (size_q)
      2'd0:    strb = 4'b0001 << addr_q[1:0];
      2'd1:    strb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  // Commit write lanes at the edge that ends the ACCESS cycle. Memory is never reset.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && state == S_ACCESS && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) mem[addr_q[ADDR_WIDTH+1:2]][8*i +: 8] <= sHWDATA[8*i +: 8];
      end
    end
  end

  // Read data comes straight from the array during a read ACCESS cycle.
  // Outside those cycles, sHRDATA holds its previous value.
  assign rd_active = (state == S_ACCESS) && !write_q;
  assign sHRDATA   = rd_active ? mem[addr_q[ADDR_WIDTH+1:2]] : rdata_q;

  // Remember the last read word so sHRDATA can hold it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rdata_q <= 32'h0;
    else          rdata_q <= sHRDATA;
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed bench for ahb_sram_slave.
// Two instances share one address/data bus. dut0 uses WAIT_STATES=0 and
// dut3 uses WAIT_STATES=3. Bus HREADY is the AND of both HREADYOUTs.
// When AHB_SRAM_WRITE_PROTECT_EN is defined, the bench also drives wp_i.
module tb_ahb_sram_slave;

  logic        clk;
  logic        rst_n;
  logic        sel0, sel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        ready0, resp0, ready3, resp3;
  logic [31:0] rdata0, rdata3;
  logic [2:0]  dbg0, dbg3;
`ifdef AHB_SRAM_WRITE_PROTECT_EN
  logic        wp;
`endif

  int          errors;
  int          checks;
  logic [31:0] r_data;
  logic        r_resp;
  logic        r_first;
  int          r_waits;
  int          n;

  assign hready = ready0 & ready3;

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .sHSEL(sel0), .sHADDR(haddr), .sHTRANS(htrans),
    .sHWRITE(hwrite), .sHSIZE(hsize), .sHBURST(hburst), .sHWDATA(hwdata), .sHREADY(hready),
`ifdef AHB_SRAM_WRITE_PROTECT_EN
    .wp_i(wp),
`endif
    .sHREADYOUT(ready0), .sHRESP(resp0), .sHRDATA(rdata0), .dbg_state(dbg0)
  );

  ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .sHSEL(sel3), .sHADDR(haddr), .sHTRANS(htrans),
    .sHWRITE(hwrite), .sHSIZE(hsize), .sHBURST(hburst), .sHWDATA(hwdata), .sHREADY(hready),
`ifdef AHB_SRAM_WRITE_PROTECT_EN
    .wp_i(wp),
`endif
    .sHREADYOUT(ready3), .sHRESP(resp3), .sHRDATA(rdata3), .dbg_state(dbg3)
  );

  // Scoreboard comparison point.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    sel0   = 1'b0;
    sel3   = 1'b0;
    htrans = 2'b00;
  endtask

  // Driver: run one non-pipelined transfer on dut0 or dut3.
  // It returns the read data, the final response, the response seen in the
  // first data cycle, and the number of cycles with HREADY low.
  task automatic do_xfer(input bit use3, input logic [31:0] addr, input bit write,
                         input logic [2:0] size, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic resp,
                         output logic first_resp, output int waits);
    tick();
    sel0   = !use3;
    sel3   = use3;
    haddr  = addr;
    htrans = 2'b10;
    hwrite = write;
    hsize  = size;
    tick();
    bus_idle();
    hwdata = wdata;
    #1;
    first_resp = use3 ? resp3 : resp0;
    waits = 0;
    while (!hready && waits < 20) begin
      waits++;
      tick();
    end
    rdata = use3 ? rdata3 : rdata0;
    resp  = use3 ? resp3 : resp0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    sel0   = 1'b0;
    sel3   = 1'b0;
    haddr  = 32'h0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd2;
    hburst = 3'd0;
    hwdata = 32'h0;
`ifdef AHB_SRAM_WRITE_PROTECT_EN
    wp = 1'b0;
`endif
    #3;
    check("rst_ready0", ready0, 1);
    check("rst_resp0", resp0, 0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_ready3", ready3, 1);
    check("rst_dbg0", dbg0, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Back-to-back write then read of 0x10 on the zero-wait slave.
    tick();
    sel0 = 1'b1; haddr = 32'h10; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    tick();
    hwdata = 32'hDEADBEEF;
    hwrite = 1'b0;
    #1;
    check("b2b_wr_ready", ready0, 1);
    check("b2b_wr_resp", resp0, 0);
    tick();
    bus_idle();
    #1;
    check("b2b_rd_ready", ready0, 1);
    check("b2b_rd_data", rdata0, 32'hDEADBEEF);
    check("b2b_rd_resp", resp0, 0);
    tick();
    #1;
    check("rdata_hold", rdata0, 32'hDEADBEEF);

    // Byte and halfword lane merging.
    do_xfer(0, 32'h10, 1, 3'd2, 32'h11223344, r_data, r_resp, r_first, r_waits);
    do_xfer(0, 32'h13, 1, 3'd0, 32'hAAAAAAAA, r_data, r_resp, r_first, r_waits);
    do_xfer(0, 32'h10, 0, 3'd2, 32'h0, r_data, r_resp, r_first, r_waits);
    check("byte_merge", r_data, 32'hAA223344);
    check("byte_waits", r_waits, 0);
    do_xfer(0, 32'h12, 1, 3'd1, 32'h55665566, r_data, r_resp, r_first, r_waits);
    do_xfer(0, 32'h10, 0, 3'd2, 32'h0, r_data, r_resp, r_first, r_waits);
    check("half_hi_merge", r_data, 32'h55663344);
    do_xfer(0, 32'h10, 1, 3'd1, 32'h99889988, r_data, r_resp, r_first, r_waits);
    do_xfer(0, 32'h10, 0, 3'd2, 32'h0, r_data, r_resp, r_first, r_waits);
    check("half_lo_merge", r_data, 32'h55669988);
    check("half_lo_resp", r_resp, 0);

    // Error responses leave memory unchanged.
    do_xfer(0, 32'h0, 1, 3'd2, 32'h12345678, r_data, r_resp, r_first, r_waits);
    do_xfer(0, 32'h2, 1, 3'd2, 32'hFFFFFFFF, r_data, r_resp, r_first, r_waits);
    check("err_word_first", r_first, 1);
    check("err_word_waits", r_waits, 1);
    check("err_word_resp", r_resp, 1);
    do_xfer(0, 32'h1, 1, 3'd1, 32'hFFFFFFFF, r_data, r_resp, r_first, r_waits);
    check("err_half_waits", r_waits, 1);
    check("err_half_resp", r_resp, 1);
    do_xfer(0, 32'h1000, 1, 3'd2, 32'hFFFFFFFF, r_data, r_resp, r_first, r_waits);
    check("err_range_waits", r_waits, 1);
    check("err_range_resp", r_resp, 1);
    do_xfer(0, 32'h0, 0, 3'd2, 32'h0, r_data, r_resp, r_first, r_waits);
    check("err_mem_kept", r_data, 32'h12345678);
    check("err_after_resp", r_resp, 0);

    // IDLE, BUSY and unselected NONSEQ cycles must not access memory.
    tick();
    sel0 = 1'b1; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b1; hsize = 3'd2;
    tick();
    hwdata = 32'hFFFFFFFF;
    htrans = 2'b01;
    #1;
    check("idle_ready", ready0, 1);
    check("idle_state", dbg0, 0);
    tick();
    sel0 = 1'b0;
    htrans = 2'b10;
    #1;
    check("busy_state", dbg0, 0);
    tick();
    bus_idle();
    #1;
    check("nosel_state", dbg0, 0);
    do_xfer(0, 32'h0, 0, 3'd2, 32'h0, r_data, r_resp, r_first, r_waits);
    check("noacc_mem_kept", r_data, 32'h12345678);

    // Three-wait slave: timing, and a NONSEQ waiting during the wait states.
    do_xfer(1, 32'h0, 1, 3'd2, 32'hCAFEF00D, r_data, r_resp, r_first, r_waits);
    check("ws3_wr_waits", r_waits, 3);
    check("ws3_wr_resp", r_resp, 0);
    do_xfer(1, 32'h4, 1, 3'd2, 32'h01020304, r_data, r_resp, r_first, r_waits);
    tick();
    sel3 = 1'b1; haddr = 32'h0; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    tick();
    haddr = 32'h4;
    #1;
    check("ws3_first_low", ready3, 0);
    check("ws3_wait_state", dbg3, 1);
    n = 0;
    while (!hready && n < 20) begin
      n++;
      tick();
    end
    check("ws3_rd0_waits", n, 3);
    check("ws3_rd0_data", rdata3, 32'hCAFEF00D);
    check("ws3_rd0_state", dbg3, 2);
    tick();
    bus_idle();
    #1;
    check("ws3_pipe_accept", dbg3, 1);
    n = 0;
    while (!hready && n < 20) begin
      n++;
      tick();
    end
    check("ws3_rd1_waits", n, 3);
    check("ws3_rd1_data", rdata3, 32'h01020304);

    // Reset asserted during the WAIT state of a write abandons the write.
    do_xfer(1, 32'h20, 1, 3'd2, 32'hA5A5A5A5, r_data, r_resp, r_first, r_waits);
    tick();
    sel3 = 1'b1; haddr = 32'h20; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    tick();
    bus_idle();
    hwdata = 32'h0;
    #1;
    check("rstw_wait_low", ready3, 0);
    tick();
    rst_n = 1'b0;
    #1;
    check("rstw_ready", ready3, 1);
    check("rstw_resp", resp3, 0);
    check("rstw_rdata", rdata3, 32'h0);
    check("rstw_state", dbg3, 0);
    tick();
    tick();
    rst_n = 1'b1;
    do_xfer(1, 32'h20, 0, 3'd2, 32'h0, r_data, r_resp, r_first, r_waits);
    check("rstw_mem_kept", r_data, 32'hA5A5A5A5);
    check("rstw_rd_waits", r_waits, 3);
    do_xfer(0, 32'h10, 0, 3'd2, 32'h0, r_data, r_resp, r_first, r_waits);
    check("mem0_after_rst", r_data, 32'h55669988);

`ifdef AHB_SRAM_WRITE_PROTECT_EN
    // Write protection turns writes into ERROR responses; reads stay OKAY.
    wp = 1'b1;
    do_xfer(1, 32'h20, 1, 3'd2, 32'h0F0F0F0F, r_data, r_resp, r_first, r_waits);
    check("wp_wr_first", r_first, 1);
    check("wp_wr_waits", r_waits, 1);
    check("wp_wr_resp", r_resp, 1);
    do_xfer(1, 32'h20, 0, 3'd2, 32'h0, r_data, r_resp, r_first, r_waits);
    check("wp_rd_resp", r_resp, 0);
    check("wp_rd_data", r_data, 32'hA5A5A5A5);
    wp = 1'b0;
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
